mms_stream: RTL and testbench

Sequential max/min selector that consumes a stream of unsigned words, one per accepted handshake, and emits the maximum or minimum of each group of GROUP words. It is the streaming counterpart of the team's combinational 4-number max/min selector: the same select semantics (1 = minimum, 0 = maximum), but operands arrive serially over a valid/ready input and the result leaves over a valid/ready output. It sits between a sample producer and any consumer that needs per-group extrema, without parallel operand buses.

---
 rtl/mms_stream_if.sv | 45 ++++
 rtl/mms_stream.sv | 133 +++++++++++++
 tb/tb_mms_stream.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mms_stream_if.sv
// mms_stream_if: valid/ready bundle between a sample producer, mms_stream and a result consumer.
//   select/in_valid/in_data/in_ready : operand stream (one word per accepted handshake)
//   out_valid/out_data/out_ready     : per-group extremum result stream
//   out_idx                          : winning position in group (only with MMS_INDEX_EN)
//   busy                             : group partially accumulated or result held
// Modports: slave = mms_stream side, master = producer/consumer side.
// Optional feature macro: MMS_INDEX_EN.
interface mms_stream_if #(
  parameter int unsigned WIDTH = 8
`ifdef MMS_INDEX_EN
  , parameter int unsigned IDX_W = 2
`endif
) ();

  logic             select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef MMS_INDEX_EN
  logic [IDX_W-1:0] out_idx;
`endif
  logic             busy;

  modport slave (
    input  select, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
`ifdef MMS_INDEX_EN
    output out_idx,
`endif
    output busy
  );

  modport master (
    output select, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
`ifdef MMS_INDEX_EN
    input  out_idx,
`endif
    input  busy
  );

endinterface

// File: rtl/mms_stream.sv
// mms_stream: streaming max/min selector. Consumes GROUP unsigned words per group over a
// valid/ready input and presents the group maximum (select=0) or minimum (select=1) over a
// valid/ready output. select is taken from the first word of each group only.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mms_stream_if.slave (operand stream, result stream, busy, optional out_idx)
// Optional feature macro: MMS_INDEX_EN adds out_idx (first position holding the extremum).
module mms_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic         clk,
  input  logic         reset,
  mms_stream_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(GROUP);

  typedef enum logic {ACC, HOLD} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   best_q, best_d;
  logic               mode_q, mode_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
`ifdef MMS_INDEX_EN
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
`endif

  logic accept_c;
  logic better_c;
  logic last_c;

  // Next-state, accumulation and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef MMS_INDEX_EN
    best_idx_d  = best_idx_q;
    out_idx_d   = out_idx_q;
`endif

    accept_c = (state_q == ACC) && bus.in_valid;
    // Strict compare: ties keep the earliest word.
    better_c = mode_q ? (bus.in_data < best_q) : (bus.in_data > best_q);
    last_c   = (cnt_q == IDX_W'(GROUP - 1));

    case (state_q)
      ACC: begin
        if (accept_c) begin
          if (cnt_q == '0) begin
            best_d = bus.in_data;
            mode_d = bus.select;
            cnt_d  = IDX_W'(1);
`ifdef MMS_INDEX_EN
            best_idx_d = '0;
`endif
          end else begin
            if (better_c) begin
              best_d = bus.in_data;
`ifdef MMS_INDEX_EN
              best_idx_d = cnt_q;
`endif
            end
            if (last_c) begin
              // Final word goes straight into the result register.
              out_data_d  = better_c ? bus.in_data : best_q;
`ifdef MMS_INDEX_EN
              out_idx_d   = better_c ? cnt_q : best_idx_q;
`endif
              out_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = HOLD;
            end else begin
              cnt_d = cnt_q + IDX_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      best_q      <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef MMS_INDEX_EN
      best_idx_q  <= '0;
      out_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef MMS_INDEX_EN
      best_idx_q  <= best_idx_d;
      out_idx_q   <= out_idx_d;
`endif
    end
  end

  // in_ready/busy are forced low while reset is held so the producer never sees a stale accept.
  assign bus.in_ready  = (state_q == ACC) && !reset;
  assign bus.busy      = !reset && ((cnt_q != '0) || (state_q == HOLD));
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef MMS_INDEX_EN
  assign bus.out_idx   = out_idx_q;
`endif

endmodule

// File: tb/tb_mms_stream.sv
// tb_mms_stream: directed bench for mms_stream (WIDTH=8, GROUP=4). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
// Index checks are compiled only with MMS_INDEX_EN.
module tb_mms_stream;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pops   = 0;

  always #5 clk = ~clk;

  mms_stream_if #(
    .WIDTH(8)
`ifdef MMS_INDEX_EN
    , .IDX_W(2)
`endif
  ) bus ();

  mms_stream #(.WIDTH(8), .GROUP(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk)
    if (!reset && bus.out_valid && bus.out_ready) n_pops++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Offer one word at a falling edge and return at the falling edge after it is accepted.
  task automatic push(input logic [7:0] d, input logic sel);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.select   = sel;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check("push_timeout", 32'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_gap(input int gap, input logic [7:0] d, input logic sel);
    repeat (gap) @(negedge clk);
    push(d, sel);
    check("gap_busy", 32'(bus.busy), 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.select    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
`ifdef MMS_INDEX_EN
    check("rst_out_idx", 32'(bus.out_idx), 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Max of 3,9,9,1: tie keeps first 9.
    push(8'd3, 1'b0);
    push(8'd9, 1'b0);
    push(8'd9, 1'b0);
    check("s1_no_early_valid", 32'(bus.out_valid), 0);
    push(8'd1, 1'b0);
    check("s1_out_valid", 32'(bus.out_valid), 1);
    check("s1_out_data", 32'(bus.out_data), 9);
`ifdef MMS_INDEX_EN
    check("s1_out_idx", 32'(bus.out_idx), 1);
`endif
    check("s1_in_ready_hold", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("s1_pop_valid", 32'(bus.out_valid), 0);
    check("s1_pop_in_ready", 32'(bus.in_ready), 1);
    check("s1_pop_busy", 32'(bus.busy), 0);

    // Min mode latched on first word; later select changes ignored.
    bus.out_ready = 1'b0;
    push(8'd200, 1'b1);
    push(8'd17, 1'b0);
    push(8'd255, 1'b0);
    push(8'd17, 1'b0);
    check("s2_out_valid", 32'(bus.out_valid), 1);
    check("s2_out_data", 32'(bus.out_data), 17);
`ifdef MMS_INDEX_EN
    check("s2_out_idx", 32'(bus.out_idx), 1);
`endif

    // Backpressure: result stable, input refused.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd0;
      bus.select   = 1'b1;
      @(negedge clk);
      check("s3_hold_valid", 32'(bus.out_valid), 1);
      check("s3_hold_data", 32'(bus.out_data), 17);
      check("s3_hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("s3_pop_valid", 32'(bus.out_valid), 0);
    check("s3_pop_in_ready", 32'(bus.in_ready), 1);
    check("s3_no_ghost_group", 32'(bus.busy), 0);

    // Bubbles between words.
    push_gap(0, 8'd0, 1'b0);
    push_gap(1, 8'd255, 1'b0);
    push_gap(2, 8'd128, 1'b0);
    push_gap(3, 8'd64, 1'b0);
    check("s4_out_valid", 32'(bus.out_valid), 1);
    check("s4_out_data", 32'(bus.out_data), 255);
`ifdef MMS_INDEX_EN
    check("s4_out_idx", 32'(bus.out_idx), 1);
`endif
    @(negedge clk);
    check("s4_pop_busy", 32'(bus.busy), 0);

    // Reset mid-group discards the partial group.
    push(8'd50, 1'b1);
    push(8'd60, 1'b1);
    check("s5_busy_partial", 32'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("s5_rst_in_ready", 32'(bus.in_ready), 0);
    check("s5_rst_out_valid", 32'(bus.out_valid), 0);
    check("s5_rst_out_data", 32'(bus.out_data), 0);
    check("s5_rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s5_post_busy", 32'(bus.busy), 0);
    check("s5_post_valid", 32'(bus.out_valid), 0);
    push(8'd5, 1'b1);
    push(8'd6, 1'b1);
    push(8'd7, 1'b1);
    check("s5_no_early_valid", 32'(bus.out_valid), 0);
    push(8'd8, 1'b1);
    check("s5_out_valid", 32'(bus.out_valid), 1);
    check("s5_out_data", 32'(bus.out_data), 5);
`ifdef MMS_INDEX_EN
    check("s5_out_idx", 32'(bus.out_idx), 0);
`endif

    // Last word wins; next group starts right after the pop cycle.
    @(negedge clk);
    push(8'd9, 1'b1);
    push(8'd8, 1'b1);
    push(8'd7, 1'b1);
    push(8'd6, 1'b1);
    check("s7_out_data", 32'(bus.out_data), 6);
`ifdef MMS_INDEX_EN
    check("s7_out_idx", 32'(bus.out_idx), 3);
`endif
    check("s7_in_ready_hold", 32'(bus.in_ready), 0);
    push(8'd1, 1'b0);
    check("s7_next_busy", 32'(bus.busy), 1);
    check("s7_next_valid", 32'(bus.out_valid), 0);

    check("pop_count", 32'(n_pops), 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
